// File: rtl/div_radix2_core_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM encodings,
// the divide-by-zero quotient fill bit and the HI/LO result field split.
package div_radix2_core_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Divide by zero reports an all-ones quotient and passes the dividend through as remainder.
   localparam logic DIV_ZERO_Q_BIT = 1'b1;

   // result = {HI, LO}: HI = result[2W-1:W] is the remainder, LO = result[W-1:0] is the quotient.
   localparam int DIV_HI_FIELD = 1;
   localparam int DIV_LO_FIELD = 0;

endpackage

// File: rtl/div_radix2_core_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor and shift the resulting quotient bit into the low end of dvd.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_dvd,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_dvd,
   output logic             o_q_bit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // The extra top bit keeps the borrow visible: rem < dsr, so the shifted value fits in WIDTH+1 bits.
   assign w_shift = {i_rem, i_dvd[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, i_dsr};
   assign o_q_bit = ~w_diff[WIDTH];
   assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign o_dvd   = {i_dvd[WIDTH-2:0], o_q_bit};

endmodule

// File: rtl/div_radix2_core.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage start/annul/ready handshake.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
//
// Handshake: the controller raises start with operands and holds it; the core
// raises ready with result = {remainder, quotient} and holds both until start
// drops or annul is seen. annul always wins and abandons any work in progress.
module div_radix2_core
   import div_radix2_core_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 start,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready,
   output div_state_e           dbg_state
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

   div_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dsr;
   logic               r_sign_q;
   logic               r_sign_r;
   logic [2*WIDTH-1:0] r_result;
   logic               r_ready;

   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_rem_n;
   logic [WIDTH-1:0]   w_dvd_n;
   logic               w_q_bit;
   logic [WIDTH-1:0]   w_q_final;

   assign w_neg_a = signed_div & opdata1[WIDTH-1];
   assign w_neg_b = signed_div & opdata2[WIDTH-1];
   assign w_abs_a = w_neg_a ? -opdata1 : opdata1;
   assign w_abs_b = w_neg_b ? -opdata2 : opdata2;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem   (r_rem),
      .i_dvd   (r_dvd),
      .i_dsr   (r_dsr),
      .o_rem   (w_rem_n),
      .o_dvd   (w_dvd_n),
      .o_q_bit (w_q_bit)
   );

   assign w_q_final = {r_dvd[WIDTH-2:0], w_q_bit};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= DIV_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               r_ready <= 1'b0;
               if (!annul && start) begin
                  if (opdata2 == '0) begin
                     r_result <= {opdata1, {WIDTH{DIV_ZERO_Q_BIT}}};
                     r_state  <= DIV_DONE;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (w_abs_a < w_abs_b) begin
                     r_result <= {opdata1, {WIDTH{1'b0}}};
                     r_state  <= DIV_DONE;
                  end
`endif
                  else begin
                     r_rem    <= '0;
                     r_dvd    <= w_abs_a;
                     r_dsr    <= w_abs_b;
                     r_sign_q <= w_neg_a ^ w_neg_b;
                     r_sign_r <= w_neg_a;
                     r_cnt    <= '0;
                     r_state  <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (annul) begin
                  r_state <= DIV_IDLE;
               end else begin
                  r_rem <= w_rem_n;
                  r_dvd <= w_dvd_n;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT) begin
                     r_result <= {(r_sign_r ? -w_rem_n : w_rem_n),
                                  (r_sign_q ? -w_q_final : w_q_final)};
                     r_state  <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               // A start still held here belongs to the finished request and must not restart.
               if (annul || !start) begin
                  r_ready <= 1'b0;
                  r_state <= DIV_IDLE;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_ready <= 1'b0;
               r_state <= DIV_IDLE;
            end
         endcase
      end
   end

   assign result    = r_result;
   assign ready     = r_ready;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_div_radix2_core.sv
// Self-checking bench for div_radix2_core: directed cases plus random operations
// compared against an arithmetic reference model (quotient/remainder and latency).
module tb_div_radix2_core;
   import div_radix2_core_pkg::*;

   localparam int W = 32;

   logic           clk;
   logic           resetn;
   logic           signed_div;
   logic [W-1:0]   opdata1;
   logic [W-1:0]   opdata2;
   logic           start;
   logic           annul;
   logic [2*W-1:0] result;
   logic           ready;
   div_state_e     dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W-1:0] exp_q[$];

   div_radix2_core #(.WIDTH(W), .CNT_W(6)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .start      (start),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model: plain 64-bit arithmetic, truncating division
   function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      if (b == '0) return {a, {W{1'b1}}};
      if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int ref_lat(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ma, mb;
      if (b == '0) return 1;
      ma = (sd && a[W-1]) ? -longint'($signed(a)) : longint'({32'b0, a});
      mb = (sd && b[W-1]) ? -longint'($signed(b)) : longint'({32'b0, b});
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`else
      if (ma < 0 || mb < 0) return 0;
`endif
      return W + 1;
   endfunction

   // driver: present a request and hold it until ready; returns edges after the sampling edge
   task automatic run_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output int lat);
      @(negedge clk);
      signed_div = sd;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      while (!ready && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = result;
   endtask

   task automatic release_op(input string tag);
      @(negedge clk);
      start = 1'b0;
      annul = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, "_rel_ready"}, 64'(ready), 64'd0);
      check_eq({tag, "_rel_state"}, 64'(dbg_state), 64'(DIV_IDLE));
      @(negedge clk);
      annul = 1'b0;
   endtask

   task automatic do_case(input string tag, input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] res;
      int lat;
      exp_q.push_back(ref_div(sd, a, b));
      run_op(sd, a, b, res, lat);
      check_eq({tag, "_lat"}, 64'(lat), 64'(ref_lat(sd, a, b)));
      check_eq({tag, "_res"}, res, exp_q.pop_front());
      release_op(tag);
   endtask

   initial begin
      logic [2*W-1:0] res;
      int lat;
      int saw_ready;
      logic [W-1:0] ra, rb;
      logic rsd;

      resetn = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
      start = 1'b0; annul = 1'b0;
      #12;
      check_eq("rst_result", result, 64'd0);
      check_eq("rst_ready", 64'(ready), 64'd0);
      check_eq("rst_state", 64'(dbg_state), 64'(DIV_IDLE));
      @(negedge clk);
      resetn = 1'b1;

      // directed cases
      do_case("u100_7", 1'b0, 32'd100, 32'd7);
      do_case("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
      do_case("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
      do_case("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      do_case("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
      do_case("div0", 1'b0, 32'h1234, 32'd0);
      do_case("u3_10", 1'b0, 32'd3, 32'd10);
      do_case("s_m3_10", 1'b1, 32'hFFFFFFFD, 32'd10);

      // annul at counter = 10: no result, ready never rises
      @(negedge clk);
      signed_div = 1'b0; opdata1 = 32'h1000; opdata2 = 32'd3; start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      @(posedge clk);
      #1;
      check_eq("annul_state", 64'(dbg_state), 64'(DIV_IDLE));
      @(negedge clk);
      annul = 1'b0; start = 1'b0;
      saw_ready = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready) saw_ready = 1;
      end
      check_eq("annul_no_ready", 64'(saw_ready), 64'd0);
      do_case("after_annul_5_5", 1'b0, 32'd5, 32'd5);

      // start and annul together in IDLE: annul wins
      @(negedge clk);
      opdata1 = 32'd9; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
      @(posedge clk);
      #1;
      check_eq("start_annul_state", 64'(dbg_state), 64'(DIV_IDLE));
      @(negedge clk);
      start = 1'b0; annul = 1'b0;

      // held start in DONE must not restart
      run_op(1'b0, 32'd50, 32'd5, res, lat);
      repeat (3) @(posedge clk);
      #1;
      check_eq("hold_ready", 64'(ready), 64'd1);
      check_eq("hold_result", result, {32'd0, 32'd10});
      release_op("hold");

      // async reset mid-BUSY
      @(negedge clk);
      signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd3; start = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("arst_result", result, 64'd0);
      check_eq("arst_ready", 64'(ready), 64'd0);
      check_eq("arst_state", 64'(dbg_state), 64'(DIV_IDLE));
      @(negedge clk);
      start = 1'b0;
      resetn = 1'b1;

      // random stimulus
      for (int i = 0; i < 24; i++) begin
         rsd = 1'($urandom_range(1, 0));
         ra  = $urandom;
         case ($urandom_range(3, 0))
            0: rb = '0;
            1: rb = 32'($urandom_range(15, 1));
            2: rb = -32'($urandom_range(15, 1));
            default: rb = $urandom;
         endcase
         do_case($sformatf("rnd%0d", i), rsd, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div_radix2_core.md
Name: div_radix2_core

Overview:
- Multi-cycle radix-2 restoring divider: the responder on the EX-stage divide handshake (start / annul / ready).
- The divide controller holds start with operands and a sign flag.
- The core computes, raises ready with {remainder, quotient}, and waits for the controller to release it.
- The result feeds the HI/LO write path: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1  in  WIDTH  dividend; sampled with start.
- opdata2  in  WIDTH  divisor; sampled with start.
- start  in  1  request; level, held by the controller until ready.
- annul  in  1  abort/release (controller refresh OR pipeline clear); highest priority after reset.
- result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, registered.
- ready  out  1  result valid, registered.

Behaviour:
- Reset (resetn=0, async): state=IDLE, result=0, ready=0, counter=0, operand registers=0. A reset mid-operation discards all work.
- States: IDLE, BUSY, DONE.
- IDLE:
  - annul=1: stay IDLE.
  - start=1, divisor=0: go to DONE, result={opdata1, {WIDTH{1'b1}}}.
  - start=1, divisor!=0: latch |dividend|, |divisor| (two's-complement abs when signed_div=1), latch sign_q = dividend sign XOR divisor sign and sign_r = dividend sign (both forced to 0 when unsigned), clear the partial remainder, counter=0, go to BUSY.
- BUSY, one iteration per cycle:
  - Shift {rem, dvd} left by 1.
  - Trial subtract the divisor from rem (WIDTH+1 bits).
  - If nonnegative, rem = difference and quotient bit = 1; otherwise quotient bit = 0.
  - Counter increments. On the iteration with counter = WIDTH-1, register result with sign fix-up (quotient negated if sign_q, remainder negated if sign_r) and go to DONE.
  - annul=1: go to IDLE immediately, no result update.
  - Input changes during BUSY are ignored.
- DONE: ready=1, result stable. Go to IDLE when annul=1 or start=0; otherwise stay. A still-high start never restarts.
- Latency:
  - Start sampled at edge E0 gives ready high after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - Divide by zero: ready after E1.
- ready is 0 in IDLE and BUSY. result holds its last value outside DONE.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
- Simultaneous start and annul in IDLE: annul wins, stay IDLE.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE with divisor!=0 and |dividend| < |divisor| (unsigned compare of absolutes), go directly to DONE with quotient=0 and remainder=original dividend; ready after E1.
- Undefined: every nonzero-divisor operation takes the full WIDTH+1 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package/defines header: state encodings (DIV_IDLE, DIV_BUSY, DIV_DONE), the divide-by-zero quotient constant, and the result field split (HI = [2W-1:W], LO = [W-1:0]).
- One sub-module, div_step: combinational single-iteration shift/trial-subtract returning next rem, next dvd and the quotient bit. It is instanced once in the core.

Test Plan:
- Unsigned 100/7, start held: ready after exactly 33 edges, result = {32'd2, 32'd14}. Drop start and pulse annul: ready=0 the next cycle, state IDLE.
- Signed -7/2 (0xFFFFFFF9, 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD, remainder 1.
- Signed 0x80000000/0xFFFFFFFF: result = {0, 0x80000000}. Unsigned 0xFFFFFFFF/1: result = {0, 0xFFFFFFFF}.
- Divisor 0 with dividend 0x1234: ready after 1 edge, result = {0x1234, 0xFFFFFFFF}.
- Annul at BUSY counter=10: IDLE the next cycle, ready never rises. A new start 5/5 then yields {0, 1} after 33 edges.
- Deassert resetn asynchronously mid-BUSY: ready and result go to 0 immediately. With DIV_EARLY_OUT_EN defined, 3/10 unsigned gives {3, 0} after 1 edge.
